// File: rtl/fifo_wr_arb_pkg.sv
// Shared types, limits and helpers for the FIFO write-port arbiter.
// Used by fifo_wr_arbiter and rr_pick.
package fifo_wr_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } state_t;

   localparam int unsigned NUM_REQ_MIN = 2;
   localparam int unsigned NUM_REQ_MAX = 8;
   localparam int unsigned IDX_MAX_W   = $clog2(NUM_REQ_MAX);

   // Encode a one-hot (or zero) vector to its bit index; zero maps to 0.
   function automatic logic [IDX_MAX_W-1:0] onehot2idx(input logic [NUM_REQ_MAX-1:0] oh);
      logic [IDX_MAX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_REQ_MAX; i++) begin
         if (oh[i]) idx = idx | IDX_MAX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req at or after
// i_start (wrapping modulo NUM_REQ), returned one-hot with a found flag.
module rr_pick
   import fifo_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_start,
   output logic [NUM_REQ-1:0] o_pick,
   output logic               o_found
);

   logic [IDX_W:0] w_sum;

   // Walk offsets from farthest to nearest so the nearest request wins.
   always_comb begin
      o_pick = '0;
      w_sum  = '0;
      for (int unsigned k = NUM_REQ; k > 0; k--) begin
         w_sum = (IDX_W+1)'(i_start) + (IDX_W+1)'(k - 1);
         if (w_sum >= (IDX_W+1)'(NUM_REQ)) w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
         if (i_req[w_sum[IDX_W-1:0]]) begin
            o_pick                    = '0;
            o_pick[w_sum[IDX_W-1:0]]  = 1'b1;
         end
      end
   end

   assign o_found = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ requesters.
// Define FIFO_WR_ARB_BURST_EN to add REQ_LAST and keep multi-word frames contiguous.
module fifo_wr_arbiter
   import fifo_wr_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8
)(
   input  logic                          W_CLK,
   input  logic                          W_RST,
   input  logic [NUM_REQ-1:0]            REQ_VALID,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
`ifdef FIFO_WR_ARB_BURST_EN
   input  logic [NUM_REQ-1:0]            REQ_LAST,
`endif
   output logic [NUM_REQ-1:0]            REQ_READY,
   input  logic                          W_FULL,
   output logic                          W_INC,
   output logic [DATA_WIDTH-1:0]         W_DATA,
   output logic [NUM_REQ-1:0]            GRANT,
   output logic                          BUSY
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
      $error("fifo_wr_arbiter: NUM_REQ out of range");
   end

   state_t               r_state, w_state_nxt;
   logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
   logic [IDX_W-1:0]     r_last_idx, w_last_idx_nxt;
   logic [IDX_W-1:0]     w_g, w_base, w_start;
   logic [NUM_REQ-1:0]   w_pick;
   logic                 w_found, w_xfer, w_abandon, w_rearb;

   assign w_g = IDX_W'(onehot2idx(NUM_REQ_MAX'(r_grant)));

   // One picker serves both paths: from IDLE start after last_idx, else after the holder.
   assign w_base  = (r_state == GRANTED) ? w_g : r_last_idx;
   assign w_start = (w_base == IDX_W'(NUM_REQ - 1)) ? '0 : w_base + IDX_W'(1);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .i_req   (REQ_VALID),
      .i_start (w_start),
      .o_pick  (w_pick),
      .o_found (w_found)
   );

   assign w_xfer    = W_INC;
   assign w_abandon = (r_state == GRANTED) & ~W_FULL & ~REQ_VALID[w_g];
`ifdef FIFO_WR_ARB_BURST_EN
   assign w_rearb   = w_abandon | (w_xfer & REQ_LAST[w_g]);
`else
   assign w_rearb   = w_abandon | w_xfer;
`endif

   always_ff @(posedge W_CLK or negedge W_RST) begin
      if (!W_RST) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_last_idx <= IDX_W'(NUM_REQ - 1);
      end else begin
         r_state    <= w_state_nxt;
         r_grant    <= w_grant_nxt;
         r_last_idx <= w_last_idx_nxt;
      end
   end

   // While FULL is high nothing transfers or abandons, so grant and state hold.
   always_comb begin
      w_state_nxt    = r_state;
      w_grant_nxt    = r_grant;
      w_last_idx_nxt = r_last_idx;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = GRANTED;
               w_grant_nxt = w_pick;
            end
         end
         GRANTED: begin
            if (w_xfer) w_last_idx_nxt = w_g;
            if (w_rearb) begin
               if (w_found) begin
                  w_grant_nxt = w_pick;
               end else begin
                  w_state_nxt = IDLE;
                  w_grant_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_grant_nxt = '0;
         end
      endcase
   end

   // Write side is gated by FULL here so the FIFO can never be overrun.
   always_comb begin
      REQ_READY = '0;
      W_INC     = 1'b0;
      W_DATA    = '0;
      BUSY      = 1'b0;
      if (r_state == GRANTED) begin
         REQ_READY = r_grant & {NUM_REQ{~W_FULL}};
         W_INC     = (|(REQ_VALID & r_grant)) & ~W_FULL;
         W_DATA    = REQ_DATA[32'(w_g) * DATA_WIDTH +: DATA_WIDTH];
         BUSY      = 1'b1;
      end
   end

   assign GRANT = r_grant;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: per-requester word sources, expected
// writes queued at stimulus time, monitor compares every W_INC cycle.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

   localparam int unsigned NR = 4;
   localparam int unsigned DW = 8;

   logic            W_CLK;
   logic            W_RST;
   logic [NR-1:0]   REQ_VALID;
   logic [NR*DW-1:0] REQ_DATA;
   logic [NR-1:0]   REQ_READY;
   logic            W_FULL;
   logic            W_INC;
   logic [DW-1:0]   W_DATA;
   logic [NR-1:0]   GRANT;
   logic            BUSY;
`ifdef FIFO_WR_ARB_BURST_EN
   logic [NR-1:0]   REQ_LAST;
`endif

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] data;
   } exp_t;

   exp_t     exp_q[$];
   exp_t     m_exp;
   int       wr_log[$];
   int       n_pass  = 0;
   int       n_total = 0;
   int       cyc     = 0;
   int       got;

   logic [8:0]    s_mem [NR][16];
   int            s_wr  [NR];
   int            s_rd  [NR];
   logic [NR-1:0] hs = '0;

   fifo_wr_arbiter #(
      .NUM_REQ    (NR),
      .DATA_WIDTH (DW)
   ) dut (
      .W_CLK     (W_CLK),
      .W_RST     (W_RST),
      .REQ_VALID (REQ_VALID),
      .REQ_DATA  (REQ_DATA),
`ifdef FIFO_WR_ARB_BURST_EN
      .REQ_LAST  (REQ_LAST),
`endif
      .REQ_READY (REQ_READY),
      .W_FULL    (W_FULL),
      .W_INC     (W_INC),
      .W_DATA    (W_DATA),
      .GRANT     (GRANT),
      .BUSY      (BUSY)
   );

   initial begin
      W_CLK = 1'b0;
      forever #5 W_CLK = ~W_CLK;
   end

   always @(posedge W_CLK) cyc <= cyc + 1;

   // Handshakes are sampled mid-cycle and retired by the sources after the edge.
   always @(negedge W_CLK) hs <= (W_RST === 1'b1) ? (REQ_VALID & REQ_READY) : '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic push_word(input int r, input logic [7:0] d, input logic last);
      s_mem[r][s_wr[r]] = {last, d};
      s_wr[r]++;
   endtask

   task automatic expect_wr(input int r, input logic [7:0] d);
      exp_q.push_back({2'(r), d});
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge W_CLK);
   endtask

   // Requester sources: present head word until it is accepted.
   initial begin
      for (int i = 0; i < NR; i++) begin
         s_wr[i] = 0;
         s_rd[i] = 0;
         for (int j = 0; j < 16; j++) s_mem[i][j] = '0;
      end
      REQ_VALID = '0;
      REQ_DATA  = '0;
`ifdef FIFO_WR_ARB_BURST_EN
      REQ_LAST  = '0;
`endif
      forever begin
         @(posedge W_CLK);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (hs[i]) s_rd[i]++;
            REQ_VALID[i]         = (s_rd[i] < s_wr[i]);
            REQ_DATA[i*DW +: DW] = s_mem[i][s_rd[i]][7:0];
`ifdef FIFO_WR_ARB_BURST_EN
            REQ_LAST[i]          = s_mem[i][s_rd[i]][8];
`endif
         end
      end
   end

   // Monitor: every write must match the head of the expected queue.
   always @(negedge W_CLK) begin
      if (W_RST === 1'b1 && W_INC === 1'b1) begin
         wr_log.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: got data 0x%0h grant 0x%0h, expected no write", W_DATA, GRANT);
         end else begin
            m_exp = exp_q.pop_front();
            chk("wr_grant", 32'(GRANT), 32'(1) << m_exp.idx);
            chk("wr_ready", 32'(REQ_READY), 32'(1) << m_exp.idx);
            chk("wr_data", 32'(W_DATA), 32'(m_exp.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      W_RST  = 1'b0;
      W_FULL = 1'b0;
      wait_neg(3);
      chk("rst_grant", 32'(GRANT), 32'h0);
      chk("rst_w_inc", 32'(W_INC), 32'h0);
      chk("rst_ready", 32'(REQ_READY), 32'h0);
      chk("rst_w_data", 32'(W_DATA), 32'h0);
      chk("rst_busy", 32'(BUSY), 32'h0);
      #1 W_RST = 1'b1;

      // Single word from requester 0
      @(negedge W_CLK); #1;
      push_word(0, 8'hA5, 1'b1); expect_wr(0, 8'hA5);
      @(negedge W_CLK);
      chk("single_pre_grant", 32'(GRANT), 32'h0);
      @(negedge W_CLK);
      chk("single_grant", 32'(GRANT), 32'h1);
      chk("single_busy", 32'(BUSY), 32'h1);
      wait_neg(4);
      chk("single_idle_grant", 32'(GRANT), 32'h0);
      chk("single_idle_busy", 32'(BUSY), 32'h0);

      // Requester 2 granted while FULL is high for 5 cycles
      @(negedge W_CLK); #1;
      push_word(2, 8'h3C, 1'b1); expect_wr(2, 8'h3C);
      W_FULL = 1'b1;
      @(negedge W_CLK);
      for (int k = 0; k < 5; k++) begin
         @(negedge W_CLK);
         chk("full_grant", 32'(GRANT), 32'h4);
         chk("full_w_inc", 32'(W_INC), 32'h0);
         chk("full_ready", 32'(REQ_READY), 32'h0);
      end
      @(posedge W_CLK); #1;
      W_FULL = 1'b0;
      wait_neg(5);

      // Wrap-around: bring last_idx to 3, then requesters 3 and 0 together
      @(negedge W_CLK); #1;
      push_word(3, 8'h33, 1'b1); expect_wr(3, 8'h33);
      wait_neg(6);
      @(negedge W_CLK); #1;
      push_word(3, 8'h44, 1'b1);
      push_word(0, 8'h55, 1'b1);
      expect_wr(0, 8'h55); expect_wr(3, 8'h44);
      wait_neg(7);

      // Fairness: all four valid with two words each
      @(negedge W_CLK); #1;
      wr_log.delete();
      for (int i = 0; i < NR; i++) begin
         push_word(i, 8'(8'h10 * (i + 1)), 1'b1);
         push_word(i, 8'(8'h10 * (i + 1) + 1), 1'b1);
      end
      expect_wr(0, 8'h10); expect_wr(1, 8'h20); expect_wr(2, 8'h30); expect_wr(3, 8'h40);
      expect_wr(0, 8'h11); expect_wr(1, 8'h21); expect_wr(2, 8'h31); expect_wr(3, 8'h41);
      wait_neg(13);
      chk("fair_count", 32'(wr_log.size()), 32'd8);
      chk("fair_span", (wr_log.size() == 8) ? 32'(wr_log[7] - wr_log[0]) : 32'hDEAD, 32'd7);

      // Reset asserted while a word is being written
      @(negedge W_CLK); #1;
      push_word(1, 8'h77, 1'b1);
      got = 0;
      for (int k = 0; k < 10 && got == 0; k++) begin
         @(posedge W_CLK); #2;
         if (W_INC === 1'b1) got = 1;
      end
      chk("arst_w_inc_seen", 32'(got), 32'h1);
      W_RST = 1'b0;
      #1;
      chk("arst_grant", 32'(GRANT), 32'h0);
      chk("arst_w_inc", 32'(W_INC), 32'h0);
      chk("arst_ready", 32'(REQ_READY), 32'h0);
      chk("arst_w_data", 32'(W_DATA), 32'h0);
      chk("arst_busy", 32'(BUSY), 32'h0);
      @(negedge W_CLK); #1;
      push_word(0, 8'h99, 1'b1);
      expect_wr(0, 8'h99); expect_wr(1, 8'h77);
      @(negedge W_CLK); #1;
      W_RST = 1'b1;
      wait_neg(8);

      // Three-word frame from requester 1 with requester 2 waiting
      @(negedge W_CLK); #1;
      W_RST = 1'b0;
      @(negedge W_CLK); #1;
      W_RST = 1'b1;
      push_word(1, 8'hB1, 1'b0);
      push_word(1, 8'hB2, 1'b0);
      push_word(1, 8'hB3, 1'b1);
      push_word(2, 8'hC0, 1'b1);
`ifdef FIFO_WR_ARB_BURST_EN
      expect_wr(1, 8'hB1); expect_wr(1, 8'hB2); expect_wr(1, 8'hB3); expect_wr(2, 8'hC0);
`else
      expect_wr(1, 8'hB1); expect_wr(2, 8'hC0); expect_wr(1, 8'hB2); expect_wr(1, 8'hB3);
`endif
      wait_neg(10);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
